// File: rtl/irq_aggregator.sv
// irq_aggregator: per-source edge/level interrupt latching with mask,
// lost-edge tracking and a registered fixed-priority request toward the CPU.
module irq_aggregator #(
  parameter int NUM_INTERRUPTS = 16,
  parameter int ID_WIDTH       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_INTERRUPTS-1:0] irq_src,
  input  logic [NUM_INTERRUPTS-1:0] cfg_edge,
  input  logic [NUM_INTERRUPTS-1:0] cfg_mask,
  input  logic [NUM_INTERRUPTS-1:0] ovf_clear,
  input  logic                      interrupt_ack,
  input  logic [ID_WIDTH-1:0]       interrupt_id,
  output logic [NUM_INTERRUPTS-1:0] interrupts,
  output logic                      irq_req,
  output logic [ID_WIDTH-1:0]       irq_top_id,
  output logic [NUM_INTERRUPTS-1:0] irq_pending_raw,
  output logic [NUM_INTERRUPTS-1:0] irq_overflow
);

  logic [NUM_INTERRUPTS-1:0] src_q;
  logic [NUM_INTERRUPTS-1:0] pending;
  logic [NUM_INTERRUPTS-1:0] overflow;
  logic [NUM_INTERRUPTS-1:0] rise;
  logic [NUM_INTERRUPTS-1:0] ack_hit;
  logic [NUM_INTERRUPTS-1:0] pending_d;
  logic [NUM_INTERRUPTS-1:0] overflow_d;
  logic [NUM_INTERRUPTS-1:0] masked;
  logic [ID_WIDTH-1:0]       top_id_d;

  assign rise   = irq_src & ~src_q;
  assign masked = pending & cfg_mask;

  // IDs at or above NUM_INTERRUPTS match no source and fall through.
  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < NUM_INTERRUPTS; i++) begin
      ack_hit[i] = interrupt_ack &&
                   (interrupt_id == ID_WIDTH'(i));
    end
  end

  // A rise beats a same-cycle ack; a rise onto an unacked pending bit is lost.
  always_comb begin
    pending_d  = pending;
    overflow_d = overflow & ~ovf_clear;
    for (int i = 0; i < NUM_INTERRUPTS; i++) begin
      if (!cfg_edge[i]) begin
        pending_d[i] = irq_src[i];
      end else if (rise[i]) begin
        pending_d[i] = 1'b1;
        if (pending[i] && !ack_hit[i]) begin
          overflow_d[i] = 1'b1;
        end
      end else if (ack_hit[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  // Descending scan so the lowest index wins.
  always_comb begin
    top_id_d = '0;
    for (int i = NUM_INTERRUPTS - 1; i >= 0; i--) begin
      if (masked[i]) begin
        top_id_d = ID_WIDTH'(i);
      end
    end
  end

  // src_q resets high so lines already asserted do not look like edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q           <= '1;
      pending         <= '0;
      overflow        <= '0;
      interrupts      <= '0;
      irq_req         <= 1'b0;
      irq_top_id      <= '0;
      irq_pending_raw <= '0;
      irq_overflow    <= '0;
    end else begin
      src_q           <= irq_src;
      pending         <= pending_d;
      overflow        <= overflow_d;
      interrupts      <= masked;
      irq_req         <= |masked;
      irq_top_id      <= top_id_d;
      irq_pending_raw <= pending;
      irq_overflow    <= overflow;
    end
  end

endmodule

// File: tb/tb_irq_aggregator.sv
// tb_irq_aggregator: vector table plus scoreboard for irq_aggregator,
// with a 15-source instance for out-of-range ack and mode-change cases.
module tb_irq_aggregator;

  typedef struct {
    logic        rst;
    logic [15:0] src;
    logic [15:0] edg;
    logic [15:0] mask;
    logic [15:0] oclr;
    logic        ack;
    logic [3:0]  id;
    int          n;
    logic [15:0] e_int;
    logic        e_req;
    logic [3:0]  e_top;
    logic [15:0] e_raw;
    logic [15:0] e_ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] irq_src = '0;
  logic [15:0] cfg_edge = '1;
  logic [15:0] cfg_mask = '1;
  logic [15:0] ovf_clear = '0;
  logic        interrupt_ack = 1'b0;
  logic [3:0]  interrupt_id = '0;
  logic [15:0] interrupts;
  logic        irq_req;
  logic [3:0]  irq_top_id;
  logic [15:0] irq_pending_raw;
  logic [15:0] irq_overflow;

  logic [14:0] s15 = '0;
  logic [14:0] e15 = '1;
  logic [14:0] m15 = '1;
  logic [14:0] c15 = '0;
  logic        a15 = 1'b0;
  logic [3:0]  i15 = '0;
  logic [14:0] q_int15;
  logic        q_req15;
  logic [3:0]  q_top15;
  logic [14:0] q_raw15;
  logic [14:0] q_ovf15;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  irq_aggregator #(.NUM_INTERRUPTS(16), .ID_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src),
    .cfg_edge(cfg_edge), .cfg_mask(cfg_mask),
    .ovf_clear(ovf_clear), .interrupt_ack(interrupt_ack),
    .interrupt_id(interrupt_id), .interrupts(interrupts),
    .irq_req(irq_req), .irq_top_id(irq_top_id),
    .irq_pending_raw(irq_pending_raw),
    .irq_overflow(irq_overflow)
  );

  irq_aggregator #(.NUM_INTERRUPTS(15), .ID_WIDTH(4)) dut15 (
    .clk(clk), .rst(rst), .irq_src(s15),
    .cfg_edge(e15), .cfg_mask(m15),
    .ovf_clear(c15), .interrupt_ack(a15),
    .interrupt_id(i15), .interrupts(q_int15),
    .irq_req(q_req15), .irq_top_id(q_top15),
    .irq_pending_raw(q_raw15),
    .irq_overflow(q_ovf15)
  );

  function automatic vec_t mk(
    input logic rst_v, input logic [15:0] src,
    input logic [15:0] edg, input logic [15:0] mask,
    input logic [15:0] oclr, input logic ack,
    input logic [3:0] id, input int n,
    input logic [15:0] e_int, input logic e_req,
    input logic [3:0] e_top, input logic [15:0] e_raw,
    input logic [15:0] e_ovf);
    vec_t v;
    v.rst = rst_v; v.src = src; v.edg = edg;
    v.mask = mask; v.oclr = oclr; v.ack = ack;
    v.id = id; v.n = n; v.e_int = e_int;
    v.e_req = e_req; v.e_top = e_top;
    v.e_raw = e_raw; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic check(input string nm, input int row,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h want %0h",
               nm, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int row);
    vec_t e;
    for (int k = 0; k < v.n; k++) begin
      rst = v.rst; irq_src = v.src; cfg_edge = v.edg;
      cfg_mask = v.mask; ovf_clear = v.oclr;
      interrupt_ack = v.ack; interrupt_id = v.id;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("interrupts", row, 32'(interrupts), 32'(e.e_int));
      check("irq_req", row, 32'(irq_req), 32'(e.e_req));
      check("irq_top_id", row, 32'(irq_top_id), 32'(e.e_top));
      check("pending_raw", row, 32'(irq_pending_raw), 32'(e.e_raw));
      check("overflow", row, 32'(irq_overflow), 32'(e.e_ovf));
    end
  endtask

  task automatic tick15();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset release with bit 0 held high, then a real edge
    tbl.push_back(mk(1, 16'h0001, '1, '1, 0, 0, 0, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0001, '1, '1, 0, 0, 0, 10, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0001, '1, '1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0001, '1, '1, 0, 0, 0, 1, 16'h0001, 1, 0, 16'h0001, 0));
    tbl.push_back(mk(0, 16'h0001, '1, '1, 0, 1, 0, 1, 16'h0001, 1, 0, 16'h0001, 0));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // two edges, priority, acks
    tbl.push_back(mk(0, 16'h0208, '1, '1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0208, '1, '1, 0, 0, 0, 1, 16'h0208, 1, 3, 16'h0208, 0));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 1, 3, 1, 16'h0208, 1, 3, 16'h0208, 0));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 0, 0, 1, 16'h0200, 1, 9, 16'h0200, 0));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 1, 9, 1, 16'h0200, 1, 9, 16'h0200, 0));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // overflow on bit 5, clear, then rise+ack together
    tbl.push_back(mk(0, 16'h0020, '1, '1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 0, 0, 1, 16'h0020, 1, 5, 16'h0020, 0));
    tbl.push_back(mk(0, 16'h0020, '1, '1, 0, 0, 0, 1, 16'h0020, 1, 5, 16'h0020, 0));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 0, 0, 1, 16'h0020, 1, 5, 16'h0020, 16'h0020));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 16'h0020, 0, 0, 1, 16'h0020, 1, 5, 16'h0020, 16'h0020));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 0, 0, 1, 16'h0020, 1, 5, 16'h0020, 0));
    tbl.push_back(mk(0, 16'h0020, '1, '1, 0, 1, 5, 1, 16'h0020, 1, 5, 16'h0020, 0));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 0, 0, 2, 16'h0020, 1, 5, 16'h0020, 0));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 1, 5, 1, 16'h0020, 1, 5, 16'h0020, 0));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // level mode on bit 2, ack ignored
    tbl.push_back(mk(0, 16'h0004, 16'hFFFB, '1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0004, 16'hFFFB, '1, 0, 0, 0, 1, 16'h0004, 1, 2, 16'h0004, 0));
    tbl.push_back(mk(0, 16'h0004, 16'hFFFB, '1, 0, 1, 2, 1, 16'h0004, 1, 2, 16'h0004, 0));
    tbl.push_back(mk(0, 16'h0004, 16'hFFFB, '1, 0, 0, 0, 2, 16'h0004, 1, 2, 16'h0004, 0));
    tbl.push_back(mk(0, 16'h0000, 16'hFFFB, '1, 0, 0, 0, 1, 16'h0004, 1, 2, 16'h0004, 0));
    tbl.push_back(mk(0, 16'h0000, 16'hFFFB, '1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // mask on bit 7, then unmask; ack of idle id 15 ignored
    tbl.push_back(mk(0, 16'h0080, '1, 16'hFF7F, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0000, '1, 16'hFF7F, 0, 0, 0, 1, 0, 0, 0, 16'h0080, 0));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 0, 0, 1, 16'h0080, 1, 7, 16'h0080, 0));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 1, 15, 1, 16'h0080, 1, 7, 16'h0080, 0));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 0, 0, 1, 16'h0080, 1, 7, 16'h0080, 0));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 1, 7, 1, 16'h0080, 1, 7, 16'h0080, 0));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // reset mid-operation with ack, sources held through reset
    tbl.push_back(mk(0, 16'h00F0, '1, '1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0000, '1, '1, 0, 0, 0, 1, 16'h00F0, 1, 4, 16'h00F0, 0));
    tbl.push_back(mk(0, 16'h0010, '1, '1, 0, 0, 0, 1, 16'h00F0, 1, 4, 16'h00F0, 0));
    tbl.push_back(mk(0, 16'h0010, '1, '1, 0, 0, 0, 1, 16'h00F0, 1, 4, 16'h00F0, 16'h0010));
    tbl.push_back(mk(1, 16'h0010, '1, '1, 0, 1, 4, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0010, '1, '1, 0, 0, 0, 4, 0, 0, 0, 0, 0));

    foreach (tbl[r]) apply(tbl[r], r);

    // 15-source instance: out-of-range ack, then edge->level switch
    s15 = 15'h0008;
    tick15();
    s15 = 15'h0000;
    tick15();
    check("n15_int", 100, 32'(q_int15), 32'h0008);
    check("n15_top", 100, 32'(q_top15), 32'd3);
    a15 = 1'b1; i15 = 4'hF;
    tick15();
    a15 = 1'b0; i15 = 4'h0;
    tick15();
    check("n15_badack_int", 101, 32'(q_int15), 32'h0008);
    check("n15_badack_raw", 101, 32'(q_raw15), 32'h0008);
    check("n15_badack_ovf", 101, 32'(q_ovf15), 32'h0);
    e15 = 15'h7FF7;
    tick15();
    check("n15_modesw_int", 102, 32'(q_int15), 32'h0008);
    tick15();
    check("n15_level_int", 103, 32'(q_int15), 32'h0000);
    check("n15_level_req", 103, 32'(q_req15), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
